// File: rtl/vctr_strm_sched.sv
// vctr_strm_sched: round-robin scheduler sharing one vctr_fifo_strm engine between NUM_REQ
// requesters. It picks a winner among pending requests, latches that requester's length
// into eng_vector_length, performs the engine start handshake, and holds a one-hot grant
// until the engine has finished and drained. Zero-length requests are rejected with a
// req_err pulse. All outputs are registered.
//
// Optional feature macro: HM_SCHED_TIMEOUT_EN
//   When defined, a job that has not completed within TIMEOUT_CYCLES cycles of entering START
//   is abandoned: the grant drops, req_err pulses for the granted requester, and the
//   scheduler waits for eng_idle before arbitrating again.
//
// Ports:
//   clk               clock, rising edge
//   rst               synchronous active-high reset
//   req               level request per requester
//   req_length        packed lengths, requester i at [i*LENGTH_BITS +: LENGTH_BITS]
//   gnt               one-hot grant, held for the whole job
//   gnt_id            index of the granted requester, valid while |gnt
//   req_done          one-cycle completion pulse per requester
//   req_err           one-cycle error pulse (zero length, or timeout)
//   eng_start         engine start request, held until eng_ready
//   eng_vector_length length latched at grant
//   eng_ready         engine accepted start
//   eng_done          engine computation finished
//   eng_idle          engine idle
//   busy              scheduler not in IDLE

`ifndef HM_LENGTH_BITS
`define HM_LENGTH_BITS 16
`endif

module vctr_strm_sched #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned LENGTH_BITS    = `HM_LENGTH_BITS,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*LENGTH_BITS-1:0]  req_length,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [$clog2(NUM_REQ)-1:0]      gnt_id,
    output logic [NUM_REQ-1:0]              req_done,
    output logic [NUM_REQ-1:0]              req_err,
    output logic                            eng_start,
    output logic [LENGTH_BITS-1:0]          eng_vector_length,
    input  logic                            eng_ready,
    input  logic                            eng_done,
    input  logic                            eng_idle,
    output logic                            busy
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2 || LENGTH_BITS < 1) begin : gen_bad_params
        $error("vctr_strm_sched: parameter out of range");
    end

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StRun,
        StDrain
`ifdef HM_SCHED_TIMEOUT_EN
        ,
        StTout
`endif
    } state_e;

    state_e                   state_q, state_d;
    logic [ID_W-1:0]          rr_q, rr_d;
    logic [NUM_REQ-1:0]       gnt_q, gnt_d;
    logic [ID_W-1:0]          gnt_id_q, gnt_id_d;
    logic [NUM_REQ-1:0]       req_done_q, req_done_d;
    logic [NUM_REQ-1:0]       req_err_q, req_err_d;
    logic                     eng_start_q, eng_start_d;
    logic [LENGTH_BITS-1:0]   len_q, len_d;
    logic                     busy_q, busy_d;
`ifdef HM_SCHED_TIMEOUT_EN
    logic [CNT_W-1:0]         cnt_q, cnt_d;
`endif

    // Round-robin pick, scanning from rr_q upward with wrap.
    logic                     win_found;
    logic [ID_W-1:0]          win;
    logic [ID_W-1:0]          scan_idx;
    logic [LENGTH_BITS-1:0]   win_len;

    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
        if (id == ID_W'(NUM_REQ - 1)) begin
            return '0;
        end
        return id + 1'b1;
    endfunction

    always_comb begin
        win_found = 1'b0;
        win       = '0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = ID_W'((32'(rr_q) + k) % NUM_REQ);
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win       = scan_idx;
            end
        end
        win_len = req_length[32'(win)*LENGTH_BITS +: LENGTH_BITS];
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        req_done_d  = '0;
        req_err_d   = '0;
        eng_start_d = eng_start_q;
        len_d       = len_q;

        unique case (state_q)
            StIdle: begin
                if (win_found && eng_idle) begin
                    if (win_len == '0) begin
                        req_err_d[win] = 1'b1;
                        rr_d           = next_ptr(win);
                    end else begin
                        state_d     = StStart;
                        gnt_d       = NUM_REQ'(1) << win;
                        gnt_id_d    = win;
                        len_d       = win_len;
                        eng_start_d = 1'b1;
                    end
                end
            end
            StStart: begin
                if (eng_ready) begin
                    eng_start_d = 1'b0;
                    state_d     = StRun;
                end
            end
            StRun: begin
                if (eng_done) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Engine output may still be draining while eng_done is high.
                if (!eng_done && eng_idle) begin
                    state_d              = StIdle;
                    gnt_d                = '0;
                    gnt_id_d             = '0;
                    req_done_d[gnt_id_q] = 1'b1;
                    rr_d                 = next_ptr(gnt_id_q);
                end
            end
`ifdef HM_SCHED_TIMEOUT_EN
            StTout: begin
                if (eng_idle) begin
                    state_d = StIdle;
                end
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef HM_SCHED_TIMEOUT_EN
        // Counter is zero on entry to START since it is held clear everywhere else.
        cnt_d = '0;
        if (state_q == StStart || state_q == StRun || state_q == StDrain) begin
            cnt_d = cnt_q + 1'b1;
            // A normal DRAIN exit in the same cycle wins over the watchdog.
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1) && state_d != StIdle) begin
                state_d             = StTout;
                gnt_d               = '0;
                gnt_id_d            = '0;
                eng_start_d         = 1'b0;
                req_err_d           = '0;
                req_err_d[gnt_id_q] = 1'b1;
                rr_d                = next_ptr(gnt_id_q);
            end
        end
`endif

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rr_q        <= '0;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            req_done_q  <= '0;
            req_err_q   <= '0;
            eng_start_q <= 1'b0;
            len_q       <= '0;
            busy_q      <= 1'b0;
`ifdef HM_SCHED_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            req_done_q  <= req_done_d;
            req_err_q   <= req_err_d;
            eng_start_q <= eng_start_d;
            len_q       <= len_d;
            busy_q      <= busy_d;
`ifdef HM_SCHED_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign gnt               = gnt_q;
    assign gnt_id            = gnt_id_q;
    assign req_done          = req_done_q;
    assign req_err           = req_err_q;
    assign eng_start         = eng_start_q;
    assign eng_vector_length = len_q;
    assign busy              = busy_q;

endmodule

// File: tb/tb_vctr_strm_sched.sv
// Self-checking bench for vctr_strm_sched (NUM_REQ=4, LENGTH_BITS=8, TIMEOUT_CYCLES=16).
// A behavioural model tracks the round-robin pointer and computes each winner by scanning
// the request mask; the bench itself plays the engine side of the handshake.

module tb_vctr_strm_sched;

    localparam int NR = 4;
    localparam int LB = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*LB-1:0]  req_length;
    logic [NR-1:0]     gnt;
    logic [1:0]        gnt_id;
    logic [NR-1:0]     req_done;
    logic [NR-1:0]     req_err;
    logic              eng_start;
    logic [LB-1:0]     eng_vector_length;
    logic              eng_ready;
    logic              eng_done;
    logic              eng_idle;
    logic              busy;

    int n_chk  = 0;
    int n_fail = 0;
    int rr_m   = 0;        // model round-robin pointer
    int lens[NR];          // model copy of req_length

    vctr_strm_sched #(
        .NUM_REQ       (NR),
        .LENGTH_BITS   (LB),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req              (req),
        .req_length       (req_length),
        .gnt              (gnt),
        .gnt_id           (gnt_id),
        .req_done         (req_done),
        .req_err          (req_err),
        .eng_start        (eng_start),
        .eng_vector_length(eng_vector_length),
        .eng_ready        (eng_ready),
        .eng_done         (eng_done),
        .eng_idle         (eng_idle),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int i, input int v);
        lens[i] = v;
        req_length[i*LB +: LB] = LB'(v);
    endtask

    // Reference arbitration: first requester at or after rr_m, modulo NR.
    function automatic int pick(input logic [NR-1:0] r);
        for (int k = 0; k < NR; k++) begin
            if (r[(rr_m + k) % NR]) return (rr_m + k) % NR;
        end
        return -1;
    endfunction

    // Entered in the cycle where the grant for w is expected to be visible.
    task automatic do_job(input int w, input int rdly, input int run_n, input int drn_n);
        logic [NR-1:0] eg;
        eg = NR'(1) << w;
        n_chk++; if (gnt !== eg) begin n_fail++; $display("FAIL job_gnt: got %b want %b", gnt, eg); end
        n_chk++; if (gnt_id !== 2'(w)) begin n_fail++; $display("FAIL job_gnt_id: got %0d want %0d", gnt_id, w); end
        n_chk++; if (eng_start !== 1'b1) begin n_fail++; $display("FAIL job_start: got %b want 1", eng_start); end
        n_chk++; if (eng_vector_length !== LB'(lens[w])) begin n_fail++; $display("FAIL job_len: got %0d want %0d", eng_vector_length, lens[w]); end
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL job_busy: got %b want 1", busy); end
        n_chk++; if ((req_err | req_done) !== '0) begin n_fail++; $display("FAIL job_pulses: got err %b done %b want 0", req_err, req_done); end
        for (int k = 0; k < rdly; k++) begin
            tick();
            n_chk++; if (eng_start !== 1'b1) begin n_fail++; $display("FAIL start_hold: got %b want 1 (cycle %0d)", eng_start, k + 1); end
        end
        eng_ready = 1'b1;
        eng_idle  = 1'b0;
        tick();
        eng_ready = 1'b0;
        n_chk++; if (eng_start !== 1'b0) begin n_fail++; $display("FAIL start_drop: got %b want 0", eng_start); end
        for (int k = 0; k < run_n; k++) begin
            tick();
            n_chk++; if (gnt !== eg || req_done !== '0) begin n_fail++; $display("FAIL run_hold: got gnt %b done %b want gnt %b done 0", gnt, req_done, eg); end
            n_chk++; if (eng_vector_length !== LB'(lens[w])) begin n_fail++; $display("FAIL len_stable: got %0d want %0d", eng_vector_length, lens[w]); end
        end
        eng_done = 1'b1;
        tick();
        for (int k = 0; k < drn_n; k++) begin
            tick();
            n_chk++; if (gnt !== eg || req_done !== '0) begin n_fail++; $display("FAIL drain_hold: got gnt %b done %b want gnt %b done 0", gnt, req_done, eg); end
        end
        eng_done = 1'b0;
        eng_idle = 1'b1;
        tick();
        n_chk++; if (req_done !== eg) begin n_fail++; $display("FAIL job_done: got %b want %b", req_done, eg); end
        n_chk++; if (gnt !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL job_release: got gnt %b busy %b want 0 0", gnt, busy); end
        rr_m = (w + 1) % NR;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req = '0;
        eng_ready = 1'b0;
        eng_done  = 1'b0;
        eng_idle  = 1'b1;
        tick();
        tick();
        rst  = 1'b0;
        rr_m = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NR; i++) set_len(i, 0);
        apply_reset();
        n_chk++; if (gnt !== '0 || gnt_id !== '0) begin n_fail++; $display("FAIL reset_gnt: got %b/%0d want 0/0", gnt, gnt_id); end
        n_chk++; if (req_done !== '0 || req_err !== '0) begin n_fail++; $display("FAIL reset_pulses: got %b/%b want 0/0", req_done, req_err); end
        n_chk++; if (eng_start !== 1'b0 || eng_vector_length !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_eng: got start %b len %0d busy %b want 0", eng_start, eng_vector_length, busy); end
    endtask

    task automatic test_single();
        set_len(1, 8);
        req = 4'b0010;
        tick();
        do_job(pick(req), 0, 3, 2);
        req = '0;
        tick();
        n_chk++; if (gnt !== '0 || req_done !== '0) begin n_fail++; $display("FAIL single_after: got gnt %b done %b want 0", gnt, req_done); end
    endtask

    task automatic test_fairness();
        int order[6] = '{0, 1, 3, 0, 1, 3};
        apply_reset();
        for (int i = 0; i < NR; i++) set_len(i, $urandom_range(1, 255));
        req = 4'b1011;
        tick();
        for (int j = 0; j < 6; j++) begin
            n_chk++; if (gnt_id !== 2'(order[j])) begin n_fail++; $display("FAIL fair_order: job %0d got %0d want %0d", j, gnt_id, order[j]); end
            do_job(pick(req), 0, 1, 0);
            if (j != 5) tick();
        end
        req = '0;
        tick();
    endtask

    task automatic test_zero_length();
        set_len(2, 0);
        req = 4'b0100;
        tick();
        n_chk++; if (req_err !== 4'b0100) begin n_fail++; $display("FAIL zero_err: got %b want 0100", req_err); end
        n_chk++; if (gnt !== '0 || eng_start !== 1'b0 || req_done !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_quiet: got gnt %b start %b done %b busy %b want 0", gnt, eng_start, req_done, busy); end
        rr_m = 3;
        // rr_ptr now 3: with every requester asking, 3 must win.
        for (int i = 0; i < NR; i++) set_len(i, 5 + i);
        req = 4'b1111;
        tick();
        do_job(pick(req), 1, 1, 1);
        req = '0;
        tick();
    endtask

    task automatic test_busy_handshake();
        eng_idle = 1'b0;
        set_len(0, 12);
        req = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_chk++; if (gnt !== '0 || eng_start !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL busy_engine: got gnt %b start %b busy %b want 0", gnt, eng_start, busy); end
        end
        eng_idle = 1'b1;
        tick();
        do_job(pick(req), 3, 2, 1);
        req = '0;
        tick();
    endtask

    task automatic test_reset_mid_job();
        set_len(2, 9);
        req = 4'b0100;
        tick();
        n_chk++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL rmj_gnt: got %b want 0100", gnt); end
        eng_ready = 1'b1;
        eng_idle  = 1'b0;
        tick();
        eng_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        req = '0;
        tick();
        n_chk++; if (gnt !== '0 || gnt_id !== '0 || eng_start !== 1'b0 || busy !== 1'b0 || eng_vector_length !== '0) begin n_fail++; $display("FAIL rmj_outputs: got gnt %b id %0d start %b busy %b len %0d want 0", gnt, gnt_id, eng_start, busy, eng_vector_length); end
        n_chk++; if (req_done !== '0 || req_err !== '0) begin n_fail++; $display("FAIL rmj_pulses: got %b/%b want 0/0", req_done, req_err); end
        rst = 1'b0;
        eng_idle = 1'b1;
        eng_done = 1'b0;
        rr_m = 0;
        tick();
        n_chk++; if (req_done !== '0 || gnt !== '0) begin n_fail++; $display("FAIL rmj_after: got done %b gnt %b want 0", req_done, gnt); end
        for (int i = 0; i < NR; i++) set_len(i, 20 + i);
        req = 4'b1111;
        tick();
        do_job(pick(req), 0, 2, 0);
        req = '0;
        tick();
    endtask

    task automatic test_random();
        logic [NR-1:0] eg;
        int w;
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < NR; i++) set_len(i, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255));
            req = NR'($urandom_range(1, 15));
            w = pick(req);
            if ($urandom_range(0, 2) == 0) begin
                eng_idle = 1'b0;
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                    tick();
                    n_chk++; if (gnt !== '0 || req_err !== '0) begin n_fail++; $display("FAIL rnd_busy: got gnt %b err %b want 0", gnt, req_err); end
                end
                eng_idle = 1'b1;
            end
            tick();
            if (lens[w] == 0) begin
                eg = NR'(1) << w;
                n_chk++; if (req_err !== eg || gnt !== '0 || eng_start !== 1'b0) begin n_fail++; $display("FAIL rnd_zero: got err %b gnt %b start %b want err %b", req_err, gnt, eng_start, eg); end
                rr_m = (w + 1) % NR;
                req = '0;
                tick();
                n_chk++; if (req_err !== '0) begin n_fail++; $display("FAIL rnd_err_pulse: got %b want 0", req_err); end
            end else begin
                do_job(w, $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3));
                req = '0;
                tick();
                n_chk++; if (gnt !== '0) begin n_fail++; $display("FAIL rnd_idle: got %b want 0", gnt); end
            end
        end
    endtask

`ifdef HM_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        logic [NR-1:0] eg;
        int w;
        set_len(1, 7);
        req = 4'b0010;
        w = pick(req);
        eg = NR'(1) << w;
        tick();
        n_chk++; if (gnt !== eg) begin n_fail++; $display("FAIL to_gnt: got %b want %b", gnt, eg); end
        eng_ready = 1'b1;
        eng_idle  = 1'b0;
        for (int t = 1; t < 16; t++) begin
            tick();
            eng_ready = 1'b0;
            n_chk++; if (req_err !== '0 || gnt !== eg) begin n_fail++; $display("FAIL to_early: t=%0d got err %b gnt %b want 0 %b", t, req_err, gnt, eg); end
        end
        req = '0;
        tick();
        n_chk++; if (req_err !== eg || gnt !== '0 || req_done !== '0 || busy !== 1'b1) begin n_fail++; $display("FAIL to_fire: got err %b gnt %b done %b busy %b want %b 0 0 1", req_err, gnt, req_done, busy, eg); end
        tick();
        n_chk++; if (busy !== 1'b1 || req_err !== '0) begin n_fail++; $display("FAIL to_wait: got busy %b err %b want 1 0", busy, req_err); end
        eng_idle = 1'b1;
        tick();
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL to_return: got busy %b want 0", busy); end
        rr_m = (w + 1) % NR;
    endtask
`endif

    initial begin
        rst        = 1'b1;
        req        = '0;
        req_length = '0;
        eng_ready  = 1'b0;
        eng_done   = 1'b0;
        eng_idle   = 1'b1;
        test_reset();
        test_single();
        test_fairness();
        test_zero_length();
        test_busy_handshake();
        test_reset_mid_job();
        test_random();
`ifdef HM_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vctr_strm_sched.md
Name: vctr_strm_sched

Overview:
- Round-robin scheduler that shares one vctr_fifo_strm engine between NUM_REQ requesters.
- Arbitrates among pending requesters and programs the engine's vector_length.
- Drives the engine start handshake, holds the one-hot grant for the whole job, and signals per-requester completion.
- Grant is used upstream to steer data_in_v1/v2 and data_out enables. That steering mux is outside this block.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LENGTH_BITS, HM_LENGTH_BITS, width of one vector_length field.
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles. Used only with the optional feature.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  NUM_REQ  level request per requester.
- req_length  in  NUM_REQ*LENGTH_BITS  packed lengths; requester i uses bits [i*LENGTH_BITS +: LENGTH_BITS].
- gnt  out  NUM_REQ  one-hot grant, held for the whole job.
- gnt_id  out  $clog2(NUM_REQ)  index of the granted requester; valid while |gnt.
- req_done  out  NUM_REQ  one-cycle pulse when the job of requester i completes.
- req_err  out  NUM_REQ  one-cycle pulse: zero-length request rejected, or timeout.
- eng_start  out  1  engine start.
- eng_vector_length  out  LENGTH_BITS  length latched at grant.
- eng_ready  in  1  engine accepted start.
- eng_done  in  1  engine computation finished; engine output may still be draining.
- eng_idle  in  1  engine idle.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: every output 0; state IDLE; rr_ptr=0. A reset mid-job aborts immediately with no done/err pulse. The engine must be reset in the same cycle by system wiring.
- States: IDLE, START, RUN, DRAIN (plus TOUT with the optional feature). All outputs are registered.
- IDLE, arbitration:
  - Evaluated when |req and eng_idle.
  - Winner = first i with req[i]=1, scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - If the winner's length is 0: pulse req_err[winner], set rr_ptr=winner+1 (wraps to 0 past NUM_REQ-1), stay in IDLE.
  - Otherwise, next cycle: gnt/gnt_id set, eng_vector_length latched, eng_start=1, go to START.
  - Latency: req sampled high → gnt and eng_start high 1 cycle later.
- START: hold eng_start=1 until eng_ready is sampled high. eng_start then drops on the next edge; go to RUN.
- RUN: wait for eng_done=1, then go to DRAIN.
- DRAIN:
  - Wait for eng_done=0 and eng_idle=1.
  - Then gnt drops to 0, req_done[gnt_id] pulses for 1 cycle, rr_ptr=gnt_id+1 (wrapped), go to IDLE.
  - The next grant is no earlier than the cycle after req_done.
- Requests mid-job: req changes during START/RUN/DRAIN are ignored; the job always completes. The granted requester must drop req the cycle after req_done, or it re-enters arbitration behind the others.
- Length stability: req_length is sampled only at grant. eng_vector_length is stable from grant until the return to IDLE.
- Simultaneous requests: resolved purely by rr_ptr. Every continuously requesting client is granted within NUM_REQ jobs.
- gnt is never multi-hot; gnt and req_done for the same index are never high together.
- Busy engine: eng_idle=0 in IDLE with req pending → no grant until eng_idle=1.

Optional Feature:
- Macro: HM_SCHED_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to START and increments in START/RUN/DRAIN.
  - When it reaches TIMEOUT_CYCLES-1 without leaving DRAIN: go to TOUT, drop gnt, pulse req_err[gnt_id] (no req_done), set rr_ptr=gnt_id+1.
  - TOUT waits for eng_idle=1, then returns to IDLE.
- Undefined: no counter, no TOUT state, and no timeout-driven req_err. Zero-length req_err pulses remain.

Test Plan:
- Single job: req[1]=1, length 8, engine answers normally → gnt=4'b0010 and eng_start 1 cycle after req; eng_vector_length=8; req_done[1] pulses once after eng_done falls with eng_idle=1.
- Fairness: req=4'b1011 held through 6 jobs from reset → grant order 0,1,3,0,1,3.
- Zero length: req[2]=1, length 0 → req_err[2] pulses 1 cycle later; gnt, eng_start and req_done stay 0; rr_ptr=3.
- Start handshake and busy engine: eng_idle=0 with req[0]=1 → no grant. Then eng_idle=1 and eng_ready delayed 3 cycles → eng_start held 4 cycles, then drops.
- Reset mid-job: rst=1 in RUN → next cycle all outputs 0 and no req_done; a fresh request after release is granted normally, starting from requester 0.
- Timeout (HM_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16): eng_done never rises → req_err[gnt_id] pulses 16 cycles after entering START, gnt drops, return to IDLE after eng_idle=1.
